multicore_mem_arbiter: RTL
==========================

Name: multicore_mem_arbiter

Overview:
- Parametrised N-core RAM arbiter that is the successor to the fixed two-core coherence/memory-control front end.
- Sits between CPUS cache request channels and the single RAM port.
- Grants one requester at a time with round-robin fairness.
- Supports bounded locked bursts and reports per-channel errors.
- Aggregates per-core flushed flags into a sticky system halt.

Parameters:
- CPUS, 4: number of cache request channels (≥2).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- LOCK_MAX, 8: maximum consecutive completed accesses one channel may hold under lock (≥1).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- req_ren  in  CPUS  per-channel read request.
- req_wen  in  CPUS  per-channel write request.
- req_addr  in  CPUS*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_store  in  CPUS*DATA_W  per-channel write data, packed the same way.
- req_lock  in  CPUS  request to keep the grant after completion.
- req_wait  out  CPUS  per-channel stall.
- req_err  out  CPUS  per-channel one-cycle error strobe.
- req_load  out  DATA_W  read data, broadcast to all channels.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- flushed  in  CPUS  per-core flush-complete flag.
- halt  out  1  sticky system halt.
- grant_id  out  $clog2(CPUS)  current or last granted channel.
- busy  out  1  high while in state GRANT.

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE, rr_ptr=0, grant_id=0, lock_cnt=0, halt=0.
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0, req_err=0, req_load=0, busy=0.
- A reset mid-transaction abandons the access; RAM enables drop immediately.
- A channel requests when req_ren[i] or req_wen[i] is high. If both are high, the access is a write.
- IDLE:
  - If any channel requests, select the first requesting channel scanning rr_ptr, rr_ptr+1, … modulo CPUS.
  - Register that channel into grant_id and go to GRANT on the next edge.
  - RAM enables stay 0 in IDLE.
  - Latency: a request seen at cycle 0 produces a RAM enable at cycle 1.
- GRANT:
  - ramREN/ramWEN, ramaddr and ramstore come combinationally from channel grant_id. RAM outputs are 0 in all other states.
  - req_load = ramload whenever state=GRANT, otherwise 0.
- On ramstate=ACCESS in GRANT:
  - req_wait[grant_id]=0 in that cycle.
  - If req_lock[grant_id]=1 and lock_cnt+1<LOCK_MAX: lock_cnt++, stay in GRANT, keep grant_id. If the channel's request is low next cycle, return to IDLE.
  - Otherwise: lock_cnt=0, rr_ptr=(grant_id+1) mod CPUS, go to IDLE.
- On ramstate=ERROR in GRANT:
  - req_wait[grant_id]=0 and req_err[grant_id]=1 for that cycle only.
  - Release as in the non-lock case, regardless of req_lock.
- On ramstate FREE or BUSY in GRANT: hold.
- If the granted channel drops its request before ACCESS: return to IDLE, rr_ptr unchanged, lock_cnt=0. RAM enables fall in the same cycle.
- req_wait[i] = request[i] AND NOT (state=GRANT AND grant_id=i AND ramstate∈{ACCESS,ERROR}). It is 0 for non-requesting channels.
- Priority after release: the released channel becomes lowest priority. Back-to-back requests from all channels are served in order 0,1,…,CPUS-1,0.
- Locked bursts are capped at LOCK_MAX completed accesses, then forced release. No channel starves longer than (CPUS-1)*LOCK_MAX accesses.
- halt:
  - Registered. Set on the edge where &flushed=1 and state=IDLE.
  - Sticky until reset.
  - If &flushed rises during GRANT, halt waits until the arbiter returns to IDLE.
- busy=1 exactly when state=GRANT.
- grant_id holds its last value while IDLE.

Test Plan:
1. Reset then idle (CPUS=4): all req low → ramREN=ramWEN=0, every req_wait=0, halt=0, grant_id=0.
2. Single read: ch2 req_ren=1, addr=0x40; RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF → ramREN=1 and ramaddr=0x40 from cycle 1; req_wait[2]=0 and req_load=0xDEADBEEF on the ACCESS cycle; rr_ptr=3.
3. Round-robin: all 4 channels hold req_ren, each access completes in 1 cycle → grant order 0,1,2,3,0; no channel granted twice before every other channel is served.
4. Lock cap: LOCK_MAX=3, ch1 req_lock=1 with continuous requests, ch0 also requesting → ch1 completes 3 accesses, then ch0 is granted; ch1 is not regranted before ch0 completes.
5. Error and simultaneous read/write: ch3 with ren=wen=1 → ramWEN=1, ramREN=0; ramstate=ERROR → req_err[3]=1 for exactly one cycle, then IDLE with rr_ptr=0.
6. Halt and reset: flushed=4'b1111 raised during GRANT → halt stays 0 until the cycle after returning to IDLE, then 1 and sticky after flushed drops; nRST pulse mid-GRANT clears halt and RAM enables asynchronously.

Source files
------------

// File: rtl/multicore_mem_arbiter.sv
// Round-robin arbiter that hands one RAM port to CPUS cache channels. It supports
// capped locked bursts, per-channel error strobes and a sticky halt once all cores have flushed.
module multicore_mem_arbiter #(
  parameter int CPUS     = 4,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          req_ren,
  input  logic [CPUS-1:0]          req_wen,
  input  logic [CPUS*ADDR_W-1:0]   req_addr,
  input  logic [CPUS*DATA_W-1:0]   req_store,
  input  logic [CPUS-1:0]          req_lock,
  output logic [CPUS-1:0]          req_wait,
  output logic [CPUS-1:0]          req_err,
  output logic [DATA_W-1:0]        req_load,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [DATA_W-1:0]        ramstore,
  input  logic [DATA_W-1:0]        ramload,
  input  logic [1:0]               ramstate,
  input  logic [CPUS-1:0]          flushed,
  output logic                     halt,
  output logic [$clog2(CPUS)-1:0]  grant_id,
  output logic                     busy
);
  localparam int IW = $clog2(CPUS);
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] next_id;
  logic [IW-1:0] rr_next;
  logic [CW-1:0] lock_cnt;
  logic [CPUS-1:0] req;
  logic found;
  logic cur_req;
  logic done;
  logic err;
  logic lock_more;

  // A write wins when both enables are set, so "requesting" is simply either enable.
  assign req       = req_ren | req_wen;
  assign cur_req   = (state == GRANT) && req[grant_id];
  assign done      = cur_req && (ramstate == 2'd2);
  assign err       = cur_req && (ramstate == 2'd3);
  assign lock_more = req_lock[grant_id] && ((int'(lock_cnt) + 1) < LOCK_MAX);
  assign rr_next   = (grant_id == IW'(CPUS - 1)) ? '0 : grant_id + IW'(1);
  assign busy      = (state == GRANT);

  always_comb begin
    next_id = rr_ptr;
    found   = 1'b0;
    for (int k = 0; k < CPUS; k++) begin
      if (!found && req[(int'(rr_ptr) + k) % CPUS]) begin
        next_id = IW'((int'(rr_ptr) + k) % CPUS);
        found   = 1'b1;
      end
    end
  end

  // RAM-side signals track the granted channel combinationally, so a dropped request or a reset
  // removes the enables in the same cycle.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    req_load = '0;
    req_err  = '0;
    req_wait = req;
    if (state == GRANT) begin
      ramWEN   = req_wen[grant_id];
      ramREN   = req_ren[grant_id] & ~req_wen[grant_id];
      ramaddr  = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
      ramstore = req_store[int'(grant_id)*DATA_W +: DATA_W];
      req_load = ramload;
      if (done || err) req_wait[grant_id] = 1'b0;
      if (err) req_err[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      lock_cnt <= '0;
      halt     <= 1'b0;
    end else begin
      if (state == IDLE && (&flushed)) halt <= 1'b1;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= next_id;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // A vanished request releases without rotating priority.
          if (!cur_req) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else if (done && lock_more) begin
            lock_cnt <= lock_cnt + CW'(1);
          end else if (done || err) begin
            lock_cnt <= '0;
            rr_ptr   <= rr_next;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
